// File: rtl/esc_pwm_decoder_if.sv
// rtl/esc_pwm_decoder_if.sv - pin and command bundle between a PWM source/consumer and esc_pwm_decoder
interface esc_pwm_decoder_if;
    logic        pwm_in;
    logic [7:0]  cmd;
    logic        cmd_stb;
    logic [11:0] width_us;
    logic        locked;
    logic        err_stb;

    modport slave (
        input  pwm_in,
        output cmd, cmd_stb, width_us, locked, err_stb
    );

    modport master (
        output pwm_in,
        input  cmd, cmd_stb, width_us, locked, err_stb
    );
endinterface

// File: rtl/esc_pwm_decoder.sv
// rtl/esc_pwm_decoder.sv - servo/ESC PWM high-time decoder to 8-bit command with loss-of-signal lock
// Optional FAILSAFE_EN: on timeout, force FAILSAFE_CMD onto cmd with one cmd_stb.
module esc_pwm_decoder #(
    parameter int CLK_DIV    = 50,
    parameter int MIN_US     = 1000,
    parameter int SHIFT      = 2,
    parameter int REJ_LO_US  = 500,
    parameter int REJ_HI_US  = 2500,
    parameter int TIMEOUT_US = 25000
`ifdef FAILSAFE_EN
    ,
    parameter logic [7:0] FAILSAFE_CMD = 8'd0
`endif
) (
    input logic               clk_i,
    input logic               rst_i,
    esc_pwm_decoder_if.slave  bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, EVAL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q;
    logic          sync1_q, sync2_q, sync3_q;
    logic [11:0]   cnt_q, cnt_d;
    logic [14:0]   to_q, to_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [11:0]   width_q, width_d;
    logic          locked_q, locked_d;
    logic          cmd_stb_q, cmd_stb_d;
    logic          err_stb_q, err_stb_d;

    logic          tick, rise, fall, in_range, timed_out;
    logic [11:0]   diff_us, scaled;
    logic [7:0]    mapped;

    assign tick      = (pre_q == PW'(CLK_DIV - 1));
    assign rise      = sync2_q & ~sync3_q;
    assign fall      = ~sync2_q & sync3_q;
    assign in_range  = (cnt_q >= 12'(REJ_LO_US)) && (cnt_q <= 12'(REJ_HI_US));
    assign timed_out = (to_q >= 15'(TIMEOUT_US));
    assign diff_us   = cnt_q - 12'(MIN_US);
    assign scaled    = diff_us >> SHIFT;

    always_comb begin
        mapped = 8'd0;
        if (cnt_q >= 12'(MIN_US)) begin
            mapped = (scaled > 12'd255) ? 8'd255 : scaled[7:0];
        end
    end

    // Synchronizer resets high so a pulse already in flight at reset is never seen as a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q     <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            state_q   <= ARM;
            cnt_q     <= '0;
            to_q      <= '0;
            cmd_q     <= '0;
            width_q   <= '0;
            locked_q  <= 1'b0;
            cmd_stb_q <= 1'b0;
            err_stb_q <= 1'b0;
        end else begin
            pre_q     <= tick ? '0 : pre_q + 1'b1;
            sync1_q   <= bus.pwm_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            cmd_q     <= cmd_d;
            width_q   <= width_d;
            locked_q  <= locked_d;
            cmd_stb_q <= cmd_stb_d;
            err_stb_q <= err_stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        cmd_d     = cmd_q;
        width_d   = width_q;
        locked_d  = locked_q;
        cmd_stb_d = 1'b0;
        err_stb_d = 1'b0;

        if (tick && (to_q != 15'h7FFF)) begin
            to_d = to_q + 1'b1;
        end

        if (timed_out) begin
            locked_d = 1'b0;
`ifdef FAILSAFE_EN
            if (locked_q) begin
                cmd_d     = FAILSAFE_CMD;
                cmd_stb_d = 1'b1;
            end
`endif
        end

        case (state_q)
            ARM: begin
                if (!sync2_q) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick && (cnt_q != 12'hFFF)) cnt_d = cnt_q + 1'b1;
                if (fall) state_d = EVAL;
            end
            EVAL: begin
                state_d = WAIT_RISE;
                // An accept in the same cycle as a timeout overrides it.
                if (in_range) begin
                    width_d   = cnt_q;
                    cmd_d     = mapped;
                    cmd_stb_d = 1'b1;
                    locked_d  = 1'b1;
                    to_d      = '0;
                end else begin
                    err_stb_d = 1'b1;
                end
            end
            default: state_d = ARM;
        endcase
    end

    assign bus.cmd      = cmd_q;
    assign bus.cmd_stb  = cmd_stb_q;
    assign bus.width_us = width_q;
    assign bus.locked   = locked_q;
    assign bus.err_stb  = err_stb_q;
endmodule

// File: tb/tb_esc_pwm_decoder.sv
// tb/tb_esc_pwm_decoder.sv - directed-vector self-checking bench for esc_pwm_decoder
module tb_esc_pwm_decoder;
    localparam int CLKD    = 2;
    localparam int TMO_US  = 6000;
    localparam int GAP_US  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cmd_stb = 0;
    int   n_err_stb = 0;

    esc_pwm_decoder_if bus ();

    esc_pwm_decoder #(
        .CLK_DIV    (CLKD),
        .TIMEOUT_US (TMO_US)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cmd_stb) n_cmd_stb <= n_cmd_stb + 1;
        if (bus.err_stb) n_err_stb <= n_err_stb + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * CLKD) @(posedge clk);
        #1;
    endtask

    // Drive one high pulse and check strobes exactly 4 clk after the falling drive.
    task automatic send_pulse(input string tag, input int us, input bit ok,
                              input int exp_cmd, input int exp_w);
        int cs0, es0;
        @(posedge clk); #1 bus.pwm_in = 1'b1;
        repeat (us * CLKD) @(posedge clk);
        #1 bus.pwm_in = 1'b0;
        cs0 = n_cmd_stb;
        es0 = n_err_stb;
        repeat (3) @(posedge clk);
        #1 check({tag, " early_stb"}, int'(bus.cmd_stb | bus.err_stb), 0);
        @(posedge clk); #1;
        check({tag, " cmd_stb"}, int'(bus.cmd_stb), ok ? 1 : 0);
        check({tag, " err_stb"}, int'(bus.err_stb), ok ? 0 : 1);
        check({tag, " cmd"}, int'(bus.cmd), exp_cmd);
        check({tag, " width"}, int'(bus.width_us), exp_w);
        wait_us(GAP_US);
        check({tag, " n_cmd_stb"}, n_cmd_stb - cs0, ok ? 1 : 0);
        check({tag, " n_err_stb"}, n_err_stb - es0, ok ? 0 : 1);
    endtask

    initial begin
        int cs0, es0;
        bus.pwm_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst cmd", int'(bus.cmd), 0);
        check("rst width", int'(bus.width_us), 0);
        check("rst locked", int'(bus.locked), 0);
        check("rst stb", int'(bus.cmd_stb | bus.err_stb), 0);

        // Pulse in progress at reset release must be ignored.
        rst = 1'b0;
        cs0 = n_cmd_stb;
        es0 = n_err_stb;
        wait_us(1500);
        bus.pwm_in = 1'b0;
        wait_us(GAP_US);
        check("partial n_cmd_stb", n_cmd_stb - cs0, 0);
        check("partial n_err_stb", n_err_stb - es0, 0);
        check("partial locked", int'(bus.locked), 0);

        send_pulse("p1500", 1500, 1'b1, 125, 1500);
        check("p1500 locked", int'(bus.locked), 1);
        send_pulse("p1000", 1000, 1'b1, 0, 1000);
        send_pulse("p1250", 1250, 1'b1, 62, 1250);
        send_pulse("p2000", 2000, 1'b1, 250, 2000);
        send_pulse("p2100", 2100, 1'b1, 255, 2100);
        send_pulse("p1500b", 1500, 1'b1, 125, 1500);
        send_pulse("r300", 300, 1'b0, 125, 1500);
        send_pulse("r3000", 3000, 1'b0, 125, 1500);
        check("r3000 locked", int'(bus.locked), 1);
        send_pulse("p900", 900, 1'b1, 0, 900);

        // One-clock glitch.
        cs0 = n_cmd_stb;
        es0 = n_err_stb;
        @(posedge clk); #1 bus.pwm_in = 1'b1;
        @(posedge clk); #1 bus.pwm_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("glitch n_err_stb", n_err_stb - es0, 1);
        check("glitch n_cmd_stb", n_cmd_stb - cs0, 0);
        check("glitch cmd", int'(bus.cmd), 0);

        // Loss of signal after last accepted pulse.
        send_pulse("p1500c", 1500, 1'b1, 125, 1500);
        cs0 = n_cmd_stb;
        wait_us(TMO_US - GAP_US - 100);
        check("tmo before locked", int'(bus.locked), 1);
        wait_us(200);
        check("tmo after locked", int'(bus.locked), 0);
`ifdef FAILSAFE_EN
        check("tmo cmd", int'(bus.cmd), 0);
        check("tmo n_cmd_stb", n_cmd_stb - cs0, 1);
`else
        check("tmo cmd", int'(bus.cmd), 125);
        check("tmo n_cmd_stb", n_cmd_stb - cs0, 0);
`endif

        // Reset during the high phase of an 1800 us pulse.
        send_pulse("p1800pre", 1500, 1'b1, 125, 1500);
        cs0 = n_cmd_stb;
        es0 = n_err_stb;
        @(posedge clk); #1 bus.pwm_in = 1'b1;
        wait_us(900);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst cmd", int'(bus.cmd), 0);
        check("midrst width", int'(bus.width_us), 0);
        check("midrst locked", int'(bus.locked), 0);
        rst = 1'b0;
        wait_us(900);
        bus.pwm_in = 1'b0;
        wait_us(GAP_US);
        check("midrst n_cmd_stb", n_cmd_stb - cs0, 0);
        check("midrst n_err_stb", n_err_stb - es0, 0);
        check("midrst locked after", int'(bus.locked), 0);
        send_pulse("post_rst", 1500, 1'b1, 125, 1500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
